// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types: response codes and the single-port SRAM responder states.
// Combinational only; no latency, no backpressure.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axil_resp_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_RESP,
    WR_WAIT,
    WR_RESP
  } sram_state_e;

  localparam int unsigned AXIL_ADDR_W = 32;
  localparam int unsigned AXIL_DATA_W = 32;
  localparam int unsigned AXIL_STRB_W = AXIL_DATA_W / 8;

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4), seed 8'h5A, steps every cycle.
// One-cycle register output; no backpressure.
module lfsr8 (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  assign q_d = {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};
  assign q   = q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 8'h5A;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/axil_sram.sv
// AXI4-Lite word SRAM responder, one transaction in flight; response valid 1+LATENCY+rand cycles
// after acceptance; responses hold until rready/bready, requests stall while busy.
module axil_sram
  import axil_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned RAND_BITS = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam logic [31:0] SPAN      = 32'(4 * DEPTH);
  localparam logic [7:0]  RAND_MASK = 8'((1 << RAND_BITS) - 1);
  localparam logic [4:0]  LAT_BASE  = 5'(LATENCY);

  sram_state_e state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        rvalid_q, rvalid_d;
  logic        bvalid_q, bvalid_d;

  logic [7:0]       lfsr;
  logic [4:0]       load_cnt;
  logic             idle;
  logic             rd_acc;
  logic             wr_acc;
  logic             enter_rd;
  logic             enter_wr;
  logic             mem_we;
  logic [31:0]      offset;
  logic             hit;
  logic [IDX_W-1:0] idx;
  logic [3:0][7:0]  rd_word;

  lfsr8 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  assign load_cnt = LAT_BASE + 5'(lfsr & RAND_MASK);

  // Read wins a same-cycle tie; AW and W are only ever taken together.
  assign idle    = (state_q == IDLE) && !rst;
  assign arready = idle;
  assign awready = idle && awvalid && wvalid && !arvalid;
  assign wready  = awready;
  assign rd_acc  = arready && arvalid;
  assign wr_acc  = awready;

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    if (rd_acc) begin
      addr_d = araddr;
    end else if (wr_acc) begin
      addr_d  = awaddr;
      wdata_d = wdata;
      wstrb_d = wstrb;
    end
  end

  // Decode follows addr_d so a zero-latency request is answered on acceptance.
  assign offset = addr_d - BASE_ADDR;
  assign hit    = offset < SPAN;
  assign idx    = offset[IDX_W+1:2];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rvalid_d = rvalid_q;
    bvalid_d = bvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    bresp_d  = bresp_q;
    enter_rd = 1'b0;
    enter_wr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_acc) begin
          cnt_d = load_cnt;
          if (load_cnt == 5'd0) enter_rd = 1'b1;
          else                  state_d  = RD_WAIT;
        end else if (wr_acc) begin
          cnt_d = load_cnt;
          if (load_cnt == 5'd0) enter_wr = 1'b1;
          else                  state_d  = WR_WAIT;
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q <= 5'd1) enter_rd = 1'b1;
      end
      RD_RESP: begin
        if (rready) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
        end
      end
      WR_WAIT: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q <= 5'd1) enter_wr = 1'b1;
      end
      WR_RESP: begin
        if (bready) begin
          state_d  = IDLE;
          bvalid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_rd) begin
      state_d  = RD_RESP;
      rvalid_d = 1'b1;
      rdata_d  = hit ? rd_word : 32'd0;
      rresp_d  = hit ? OKAY : DECERR;
    end
    if (enter_wr) begin
      state_d  = WR_RESP;
      bvalid_d = 1'b1;
      bresp_d  = hit ? OKAY : DECERR;
    end
  end

  // Commit on entry to WR_RESP; a reset in the same cycle drops the write.
  assign mem_we = enter_wr && hit && !rst;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (mem_we && wstrb_d[g]) begin
        mem[idx] <= wdata_d[8*g +: 8];
      end
    end
    assign rd_word[g] = mem[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      wstrb_q  <= 4'd0;
      rdata_q  <= 32'd0;
      rresp_q  <= OKAY;
      bresp_q  <= OKAY;
      rvalid_q <= 1'b0;
      bvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      bvalid_q <= bvalid_d;
    end
  end

  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign rvalid = rvalid_q;
  assign bresp  = bresp_q;
  assign bvalid = bvalid_q;

endmodule

// File: tb/tb_axil_sram.sv
// Bench for axil_sram: three instances (defaults, LATENCY=3, RAND_BITS=2) driven by directed
// and random transactions, checked against a word-array reference and latency rules.
module tb_axil_sram;

  localparam int LIMIT = 100;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk;
  logic [2:0]  rst, arvalid, arready, rvalid, rready;
  logic [2:0]  awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] araddr [3];
  logic [31:0] rdata  [3];
  logic [31:0] awaddr [3];
  logic [31:0] wdata  [3];
  logic [1:0]  rresp  [3];
  logic [1:0]  bresp  [3];
  logic [3:0]  wstrb  [3];

  int n_assert = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    axil_sram #(
      .LATENCY   (g == 1 ? 3 : 1),
      .RAND_BITS (g == 2 ? 2 : 0)
    ) u_dut (
      .clk     (clk),
      .rst     (rst[g]),
      .araddr  (araddr[g]),
      .arvalid (arvalid[g]),
      .arready (arready[g]),
      .rdata   (rdata[g]),
      .rresp   (rresp[g]),
      .rvalid  (rvalid[g]),
      .rready  (rready[g]),
      .awaddr  (awaddr[g]),
      .awvalid (awvalid[g]),
      .awready (awready[g]),
      .wdata   (wdata[g]),
      .wstrb   (wstrb[g]),
      .wvalid  (wvalid[g]),
      .wready  (wready[g]),
      .bresp   (bresp[g]),
      .bvalid  (bvalid[g]),
      .bready  (bready[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Tasks are entered and left 1 time unit after a rising edge.
  task automatic do_read(input int k, input logic [31:0] addr, input int hold,
                         input logic [31:0] exp_d, input logic [1:0] exp_r,
                         input int lo, input int hi, output int lat);
    int n;
    logic acc, got;
    araddr[k]  = addr;
    arvalid[k] = 1'b1;
    rready[k]  = 1'b0;
    n = 0; acc = 1'b0;
    while (!acc && n < LIMIT) begin
      @(negedge clk);
      acc = arready[k];
      check("rd_acc_awready_low", 32'(awready[k]), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    arvalid[k] = 1'b0;
    check("rd_accept", 32'(acc), 32'd1);
    lat = 0; got = 1'b0;
    while (!got && lat < LIMIT) begin
      lat++;
      @(negedge clk);
      if (rvalid[k]) got = 1'b1;
      else begin
        check("rd_busy_awready_low", 32'(awready[k]), 32'd0);
        @(posedge clk); #1;
      end
    end
    check("rd_valid_seen", 32'(got), 32'd1);
    if (got) begin
      check("rd_latency", 32'(lat >= lo && lat <= hi), 32'd1);
      check("rd_data", rdata[k], exp_d);
      check("rd_resp", 32'(rresp[k]), 32'(exp_r));
      for (int i = 1; i < hold; i++) begin
        @(posedge clk); @(negedge clk);
        check("rd_hold_valid", 32'(rvalid[k]), 32'd1);
        check("rd_hold_data", rdata[k], exp_d);
      end
      @(posedge clk); #1;
      rready[k] = 1'b1;
      @(posedge clk); #1;
      rready[k] = 1'b0;
      check("rd_valid_clear", 32'(rvalid[k]), 32'd0);
    end
  endtask

  task automatic do_write(input int k, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] exp_b,
                          input int lo, input int hi, output int acc_n);
    int lat;
    logic acc, got;
    awaddr[k]  = addr;
    wdata[k]   = data;
    wstrb[k]   = strb;
    awvalid[k] = 1'b1;
    wvalid[k]  = 1'b1;
    bready[k]  = 1'b0;
    acc = 1'b0; acc_n = 0;
    while (!acc && acc_n < LIMIT) begin
      @(negedge clk);
      acc = awready[k] & wready[k];
      @(posedge clk); #1;
      acc_n++;
    end
    awvalid[k] = 1'b0;
    wvalid[k]  = 1'b0;
    check("wr_accept", 32'(acc), 32'd1);
    lat = 0; got = 1'b0;
    while (!got && lat < LIMIT) begin
      lat++;
      @(negedge clk);
      if (bvalid[k]) got = 1'b1;
      else begin
        check("wr_busy_arready_low", 32'(arready[k]), 32'd0);
        @(posedge clk); #1;
      end
    end
    check("wr_valid_seen", 32'(got), 32'd1);
    if (got) begin
      check("wr_latency", 32'(lat >= lo && lat <= hi), 32'd1);
      check("wr_bresp", 32'(bresp[k]), 32'(exp_b));
      @(posedge clk); #1;
      bready[k] = 1'b1;
      @(posedge clk); #1;
      bready[k] = 1'b0;
      check("wr_valid_clear", 32'(bvalid[k]), 32'd0);
    end
  endtask

  initial begin
    int n, lat, s;
    int slot [16];
    int hist [6];
    logic [31:0] d, a;
    logic [3:0] st;
    logic [31:0] ref_mem [int];

    rst = 3'b111; arvalid = '0; rready = '0; awvalid = '0; wvalid = '0; bready = '0;
    for (int k = 0; k < 3; k++) begin
      araddr[k] = '0; awaddr[k] = '0; wdata[k] = '0; wstrb[k] = '0;
    end
    for (int i = 0; i < 6; i++) hist[i] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_arready", 32'(arready[k]), 32'd0);
      check("rst_rvalid", 32'(rvalid[k]), 32'd0);
      check("rst_bvalid", 32'(bvalid[k]), 32'd0);
      check("rst_rdata", rdata[k], 32'd0);
      check("rst_rresp", 32'(rresp[k]), 32'd0);
      check("rst_bresp", 32'(bresp[k]), 32'd0);
    end
    @(posedge clk); #1;
    rst = 3'b000;
    @(negedge clk);
    check("post_rst_arready", 32'(arready[0]), 32'd1);
    @(posedge clk); #1;

    // Defaults: full write then readback, both at t+2
    do_write(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 2, 2, n);
    do_read (0, 32'h8000_0010, 1, 32'hDEAD_BEEF, 2'b00, 2, 2, lat);

    // Partial write
    do_write(0, 32'h8000_0010, 32'h1122_3344, 4'b0101, 2'b00, 2, 2, n);
    do_read (0, 32'h8000_0010, 1, 32'hDE22_BE44, 2'b00, 2, 2, lat);

    // Zero strobe: OKAY, no change
    do_write(0, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 2'b00, 2, 2, n);
    do_read (0, 32'h8000_0010, 1, 32'hDE22_BE44, 2'b00, 2, 2, lat);

    // Range boundaries
    do_write(0, 32'h8000_0000, 32'h0BAD_F00D, 4'hF, 2'b00, 2, 2, n);
    do_write(0, 32'h8000_3FFC, 32'h7777_AAAA, 4'hF, 2'b00, 2, 2, n);
    do_read (0, 32'h8000_3FFC, 1, 32'h7777_AAAA, 2'b00, 2, 2, lat);
    do_read (0, 32'h7FFF_FFFC, 1, 32'h0000_0000, 2'b11, 2, 2, lat);
    do_write(0, 32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 2'b11, 2, 2, n);
    do_read (0, 32'h8000_0000, 1, 32'h0BAD_F00D, 2'b00, 2, 2, lat);
    do_read (0, 32'h8000_0003, 1, 32'h0BAD_F00D, 2'b00, 2, 2, lat);

    // Simultaneous AR and AW/W: read first, write the cycle after the read handshake
    awaddr[0] = 32'h8000_0020; wdata[0] = 32'hCAFE_F00D; wstrb[0] = 4'hF;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1;
    do_read (0, 32'h8000_0010, 1, 32'hDE22_BE44, 2'b00, 2, 2, lat);
    do_write(0, 32'h8000_0020, 32'hCAFE_F00D, 4'hF, 2'b00, 2, 2, n);
    check("simul_write_accept_cycle", 32'(n), 32'd1);
    do_read (0, 32'h8000_0020, 1, 32'hCAFE_F00D, 2'b00, 2, 2, lat);

    // LATENCY=3 with 5 cycles of read back-pressure
    do_write(1, 32'h8000_0040, 32'h1234_5678, 4'hF, 2'b00, 4, 4, n);
    do_read (1, 32'h8000_0040, 5, 32'h1234_5678, 2'b00, 4, 4, lat);

    // Reset during WR_WAIT drops the write
    do_write(1, 32'h8000_0100, 32'hA5A5_0F0F, 4'hF, 2'b00, 4, 4, n);
    awaddr[1] = 32'h8000_0100; wdata[1] = 32'h5A5A_F0F0; wstrb[1] = 4'hF;
    awvalid[1] = 1'b1; wvalid[1] = 1'b1;
    @(negedge clk);
    check("rstmid_accept", 32'(awready[1]), 32'd1);
    @(posedge clk); #1;
    awvalid[1] = 1'b0; wvalid[1] = 1'b0;
    @(negedge clk);
    check("rstmid_wait_bvalid", 32'(bvalid[1]), 32'd0);
    @(posedge clk); #1;
    rst[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rstmid_no_bvalid", 32'(bvalid[1]), 32'd0);
      @(posedge clk); #1;
    end
    do_read(1, 32'h8000_0100, 1, 32'hA5A5_0F0F, 2'b00, 4, 4, lat);

    // RAND_BITS=2: random traffic against the reference array
    for (int i = 0; i < 16; i++) begin
      slot[i] = int'($urandom_range(0, 4095));
      d = $urandom;
      do_write(2, BASE + 32'(slot[i] * 4), d, 4'hF, 2'b00, 2, 5, n);
      ref_mem[slot[i]] = d;
    end
    for (int i = 0; i < 100; i++) begin
      s = int'($urandom_range(0, 15));
      a = BASE + 32'(slot[s] * 4);
      if ($urandom_range(0, 3) == 0) begin
        d  = $urandom;
        st = 4'($urandom);
        do_write(2, a, d, st, 2'b00, 2, 5, n);
        ref_mem[slot[s]] = merge(ref_mem[slot[s]], d, st);
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      do_read(2, a, int'($urandom_range(1, 3)), ref_mem[slot[s]], 2'b00, 2, 5, lat);
      if (lat >= 2 && lat <= 5) hist[lat]++;
    end
    for (int v = 2; v <= 5; v++) begin
      check("rand_latency_value_seen", 32'(hist[v] > 0), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
